// File: rtl/axi_stream_wr_master_pkg.sv
// Shared definitions for the capture-stream write master: AXI response codes,
// controller state encoding and a constant-foldable log2 helper.
package axi_stream_wr_master_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_stream_wr_master_if.sv
// AW/W/B channel bundle between a write master and one slave port of the
// write arbiter; no ID signals, single outstanding burst.
interface axi_stream_wr_master_if #(
  parameter int DataBits = 64,
  parameter int AddrBits = 32,
  parameter int LenBits  = 4
);

  logic                  awvalid;
  logic                  awready;
  logic [AddrBits-1:0]   awaddr;
  logic [LenBits-1:0]    awlen;
  logic                  wvalid;
  logic                  wready;
  logic [DataBits-1:0]   wdata;
  logic [DataBits/8-1:0] wstrb;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output awvalid, awaddr, awlen,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );

endinterface

// File: rtl/axi_stream_wr_master_fifo.sv
// Synchronous valid/ready FIFO with a registered occupancy count; reusable for
// any capture path. Depth must be a power of two so the pointers wrap freely.
module stream_fifo_sync
  import axi_stream_wr_master_pkg::*;
#(
  parameter int DataBits = 64,
  parameter int Depth    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DataBits-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DataBits-1:0]   out_data,
  output logic [clog2(Depth):0] count
);

  localparam int PtrBits = clog2(Depth);
  localparam int CntBits = PtrBits + 1;

  logic [DataBits-1:0] mem [Depth];
  logic [PtrBits-1:0]  wr_ptr;
  logic [PtrBits-1:0]  rd_ptr;
  logic                push;
  logic                pop;

  assign in_ready  = (count != CntBits'(Depth));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrBits'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrBits'(1);
      case ({push, pop})
        2'b10:   count <= count + CntBits'(1);
        2'b01:   count <= count - CntBits'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count makes stale words
  // unreachable and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/axi_stream_wr_master.sv
// Drains a capture stream into fixed-length INCR bursts around a ring buffer
// in external memory; AW precedes W and only one burst is ever in flight.
module axi_stream_wr_master
  import axi_stream_wr_master_pkg::*;
#(
  parameter int DataBits  = 64,
  parameter int AddrBits  = 32,
  parameter int LenBits   = 4,
  parameter int BurstLen  = 16,
  parameter int FifoDepth = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AddrBits-1:0] cfg_base,
  input  logic [AddrBits-1:0] cfg_size,
  input  logic                ctrl_start,
  input  logic                ctrl_stop,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DataBits-1:0] in_data,
  axi_stream_wr_master_if.master mst,
  output logic                status_busy,
  output logic [AddrBits-1:0] status_wrptr,
  output logic                status_wrapped,
  output logic                status_err
);

  localparam int CntBits   = clog2(FifoDepth) + 1;
  localparam int BeatBits  = LenBits + 1;
  localparam int ByteShift = clog2(DataBits / 8);

  state_e               state_q, state_d;
  logic [AddrBits-1:0]  wrptr_q;
  logic [AddrBits-1:0]  awaddr_q;
  logic [LenBits-1:0]   awlen_q;
  logic [BeatBits-1:0]  beats_q;
  logic [BeatBits-1:0]  beat_cnt_q;
  logic                 stopping_q;
  logic                 wrapped_q;
  logic                 err_q;

  logic                 intake_open;
  logic                 fifo_in_valid;
  logic                 fifo_in_ready;
  logic                 fifo_out_valid;
  logic                 fifo_out_ready;
  logic [DataBits-1:0]  fifo_data;
  logic [CntBits-1:0]   fifo_count;
  logic                 full_burst;
  logic                 flush_burst;
  logic [BeatBits-1:0]  burst_beats;
  logic [AddrBits-1:0]  next_ptr;
  logic [AddrBits-1:0]  ring_end;
  logic                 w_fire;

  stream_fifo_sync #(
    .DataBits (DataBits),
    .Depth    (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fifo_in_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (in_data),
    .out_valid (fifo_out_valid),
    .out_ready (fifo_out_ready),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

  assign intake_open    = (state_q != ST_IDLE) && !stopping_q;
  assign in_ready       = fifo_in_ready && intake_open;
  assign fifo_in_valid  = in_valid && intake_open;
  assign fifo_out_ready = (state_q == ST_DATA) && mst.wready;
  assign w_fire         = mst.wvalid && mst.wready;

  assign mst.awvalid = (state_q == ST_ADDR);
  assign mst.awaddr  = awaddr_q;
  assign mst.awlen   = awlen_q;
  assign mst.wvalid  = (state_q == ST_DATA) && fifo_out_valid;
  assign mst.wdata   = fifo_data;
  assign mst.wstrb   = '1;
  assign mst.wlast   = (state_q == ST_DATA) && (beat_cnt_q == BeatBits'(1));
  assign mst.bready  = (state_q == ST_RESP);

  // A partial burst is only ever taken once intake has stopped, which keeps
  // every burst start aligned to the ring end.
  assign full_burst  = (fifo_count >= CntBits'(BurstLen));
  assign flush_burst = stopping_q && (fifo_count != '0);
  assign burst_beats = full_burst ? BeatBits'(BurstLen) : BeatBits'(fifo_count);
  assign next_ptr    = wrptr_q + (AddrBits'(beats_q) << ByteShift);
  assign ring_end    = cfg_base + cfg_size;

  assign status_busy    = (state_q != ST_IDLE);
  assign status_wrptr   = wrptr_q;
  assign status_wrapped = wrapped_q;
  assign status_err     = err_q;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch appears.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ctrl_start) state_d = ST_RUN;
      ST_RUN: begin
        if (full_burst || flush_burst) state_d = ST_ADDR;
        else if (stopping_q)           state_d = ST_IDLE;
      end
      ST_ADDR: if (mst.awready) state_d = ST_DATA;
      ST_DATA: if (w_fire && mst.wlast) state_d = ST_RESP;
      ST_RESP: if (mst.bvalid) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wrptr_q    <= '0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      stopping_q <= 1'b0;
      wrapped_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (ctrl_start) begin
            wrptr_q    <= cfg_base;
            stopping_q <= 1'b0;
            wrapped_q  <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (state_d == ST_ADDR) begin
            beats_q    <= burst_beats;
            beat_cnt_q <= burst_beats;
            awaddr_q   <= wrptr_q;
            awlen_q    <= LenBits'(burst_beats - BeatBits'(1));
          end
        end
        ST_DATA: begin
          if (w_fire) beat_cnt_q <= beat_cnt_q - BeatBits'(1);
        end
        ST_RESP: begin
          if (mst.bvalid) begin
            if (mst.bresp != AXI_RESP_OKAY) err_q <= 1'b1;
            if (next_ptr >= ring_end) begin
              wrptr_q   <= cfg_base;
              wrapped_q <= 1'b1;
            end else begin
              wrptr_q <= next_ptr;
            end
          end
        end
        default: ;
      endcase
      if (ctrl_stop && (state_q != ST_IDLE)) stopping_q <= 1'b1;
    end
  end

endmodule

// File: doc/axi_stream_wr_master.md
Name: axi_stream_wr_master

Overview:
- Write-side AXI master that turns a capture data stream into fixed-length INCR write bursts into a circular buffer in external memory.
- Sits directly upstream of axi_arbiter_wr: its AW/W/B channels connect to one slave port of that arbiter.
- Has at most one burst outstanding, uses no IDs, and issues AW before W, as the arbiter requires.

Parameters:
- DataBits, 64, AXI data width; a power of two, at least 8.
- AddrBits, 32, AXI address width.
- LenBits, 4, width of awlen.
- BurstLen, 16, beats per full burst; at most 2**LenBits.
- FifoDepth, 32, input FIFO depth in words; a power of two, at least BurstLen.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- cfg_base  in  AddrBits  ring start address; aligned to BurstLen*DataBits/8.
- cfg_size  in  AddrBits  ring size in bytes; a non-zero multiple of BurstLen*DataBits/8.
- ctrl_start  in  1  one-cycle pulse that arms the block.
- ctrl_stop  in  1  one-cycle pulse that stops intake and flushes.
- in_valid  in  1  stream valid.
- in_ready  out  1  stream ready.
- in_data  in  DataBits  stream word.
- mst_awvalid  out  1  write-address valid.
- mst_awready  in  1  write-address ready.
- mst_awaddr  out  AddrBits  burst address.
- mst_awlen  out  LenBits  beats-1.
- mst_wvalid  out  1  write-data valid.
- mst_wready  in  1  write-data ready.
- mst_wdata  out  DataBits  write data.
- mst_wstrb  out  DataBits/8  byte strobes; all ones.
- mst_wlast  out  1  last beat of the burst.
- mst_bvalid  in  1  write-response valid.
- mst_bready  out  1  write-response ready.
- mst_bresp  in  2  write response.
- status_busy  out  1  high whenever state is not IDLE.
- status_wrptr  out  AddrBits  next write address.
- status_wrapped  out  1  sticky; set when the ring wraps.
- status_err  out  1  sticky; set on any bresp other than 00.

Behaviour:
- Clocking and reset: one clock, clk. rst_n is synchronous, active-low.
- Reset values: state IDLE, FIFO empty, and all valids and readys 0. mst_awaddr, mst_awlen, mst_wlast and status_wrptr are 0. status_wrapped and status_err are 0.
- Reset mid-burst abandons the burst immediately, with no flush.
- Input FIFO:
  - FifoDepth words, with a registered count.
  - in_ready = !full && (state != IDLE) && !stopping.
  - A push and a pop in the same cycle leave the count unchanged.
- ctrl_start in IDLE:
  - wrptr <= cfg_base; clears status_err, status_wrapped and stopping.
  - Moves to RUN.
  - Ignored in any other state.
- ctrl_stop while not IDLE: sets stopping, which blocks further intake.
- RUN:
  - If count >= BurstLen: beats = BurstLen, go to ADDR.
  - Else if stopping and count > 0: beats = count, go to ADDR.
  - Else if stopping and count == 0: go to IDLE.
  - The beats value is latched into a beat counter.
- ADDR:
  - mst_awvalid = 1, mst_awaddr = wrptr, mst_awlen = beats-1; these are registered and held stable until mst_awready.
  - On handshake: go to DATA. AW always completes before any W beat.
- DATA:
  - mst_wvalid = FIFO not empty; mst_wdata = FIFO head. Each W handshake pops one word.
  - mst_wlast = 1 when the beat counter is 1.
  - On handshake with wlast: go to RESP.
  - The FIFO cannot underflow, because beats never exceeds count at ADDR.
- RESP:
  - mst_bready = 1.
  - On mst_bvalid: if bresp != 00, status_err <= 1.
  - next = wrptr + beats*DataBits/8. If next >= cfg_base + cfg_size, wrptr <= cfg_base and status_wrapped <= 1; otherwise wrptr <= next. Go to RUN.
- Bursts never cross the ring end: partial bursts occur only at flush, so the ring end is always burst-aligned.
- Simultaneous ctrl_stop and a full FIFO: a full burst is issued first, then the remainder is flushed.
- Throughput: a full burst takes 1 AW cycle plus BurstLen W cycles plus the B wait, with one bubble cycle back through RUN.
- cfg_* are sampled only at ctrl_start (base) and in RESP (base and size). Changing them while busy is illegal.

Decomposition:
- Shared axi package (extended): AXI_RESP_OKAY, the state encoding localparams, and a clog2 helper.
- Sub-module stream_fifo_sync with parameters DataBits and Depth, and ports in/out valid-ready, data and count. It is reusable for other capture paths.

Test Plan:
- Single full burst: DataBits=64, BurstLen=4, cfg_base=0x1000, cfg_size=0x40, start, push 4 words -> one AW with addr 0x1000 and len 3; 4 W beats with wlast on beat 4; bready high; wrptr=0x1020.
- Ring wrap: same configuration, push 8 words -> bursts at 0x1000 and 0x1020; wrptr=0x1000; status_wrapped=1.
- Partial flush: push 6 words then stop -> bursts of len 3 at 0x1000 and len 1 at 0x1020; wrptr=0x1030; then IDLE with busy=0.
- Backpressure: awready held low 10 cycles, wready toggling every other cycle, FIFO filling -> no W before the AW handshake; in_ready=0 when the FIFO is full; no data lost or reordered.
- Error response: bresp=10 on the second burst -> status_err=1 and sticky; a later start clears it.
- Reset mid-DATA: rst_n low for 1 cycle after beat 2 -> all outputs at reset values the next cycle, FIFO empty, state IDLE.
